// File: rtl/link_io_hub.sv
// link_io_hub
//   Host-visible hub for NLINKS independent streaming links. Each link owns
//   an RX FIFO (stream -> host) and a TX FIFO (host -> stream). Host accesses
//   are registered once; all decode and read data come from that stage.
//
//   Address map: address_q[7:4] = link+1 selects a link, address_q[3:0] is
//   the register offset:
//     0 : read pops the RX head (0 when empty), write pushes into TX
//     1 : status {rxCount, ovf, dor, dir}; a write with bit2 set clears ovf
//     2 : irq mask bit0 (only with LINK_IRQ_EN, otherwise reads 0)
//
//   Optional feature macro: LINK_IRQ_EN (adds the irq port and the per-link
//   mask registers).
//
//   Ports
//     clk, resetb          : clock, asynchronous active-low reset
//     vio, rnw, address    : host cycle qualifier, direction, address
//     host_din, host_dout  : host write data, host read data
//     rx_data/valid/ready  : inbound streams, link i at [i*DW +: DW]
//     tx_data/valid/ready  : outbound streams, link i at [i*DW +: DW]
//     irq                  : OR of masked RX-not-empty (LINK_IRQ_EN only)
module link_io_hub #(
   parameter int NLINKS = 4,
   parameter int DW     = 32,
   parameter int DEPTH  = 4,
   parameter int AW     = 20
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic                 vio,
   input  logic                 rnw,
   input  logic [AW-1:0]        address,
   input  logic [DW-1:0]        host_din,
   output logic [DW-1:0]        host_dout,
   input  logic [NLINKS*DW-1:0] rx_data,
   input  logic [NLINKS-1:0]    rx_valid,
   output logic [NLINKS-1:0]    rx_ready,
   output logic [NLINKS*DW-1:0] tx_data,
   output logic [NLINKS-1:0]    tx_valid,
   input  logic [NLINKS-1:0]    tx_ready
`ifdef LINK_IRQ_EN
   ,
   output logic                 irq
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [3:0] OFF_DATA = 4'd0;
   localparam logic [3:0] OFF_STAT = 4'd1;
   localparam logic [3:0] OFF_MASK = 4'd2;

   logic          vio_q;
   logic          rnw_q;
   logic [AW-1:0] address_q;
   logic [DW-1:0] host_din_q;

   logic [3:0]        offset;
   logic              hostRd;
   logic              hostWr;
   logic [NLINKS-1:0] linkSel;
   logic [DW-1:0]     rdData [NLINKS];
   logic              unusedAddr;

`ifdef LINK_IRQ_EN
   logic [NLINKS-1:0] irqReq;
   logic              irq_q;
`endif

   // Host access capture stage; everything downstream decodes these copies.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         vio_q      <= 1'b0;
         rnw_q      <= 1'b0;
         address_q  <= '0;
         host_din_q <= '0;
      end else begin
         vio_q      <= vio;
         rnw_q      <= rnw;
         address_q  <= address;
         host_din_q <= host_din;
      end
   end

   assign offset     = address_q[3:0];
   assign hostRd     = vio_q & rnw_q;
   assign hostWr     = vio_q & ~rnw_q;
   assign unusedAddr = ^address_q[AW-1:8];

   for (genvar g = 0; g < NLINKS; g++) begin : gLink
      logic [DW-1:0] rxMem_q [DEPTH];
      logic [DW-1:0] txMem_q [DEPTH];
      logic [PW-1:0] rxWr_q, rxRd_q, txWr_q, txRd_q;
      logic [CW-1:0] rxCnt_q, rxCnt_d, txCnt_q, txCnt_d;
      logic          ovf_q, ovf_d;
      logic          rxFull, rxEmpty, txFull, txEmpty;
      logic          rxPush, rxPop, txPush, txPop, ovfSet, ovfClr;
      logic [DW-1:0] rxHead, statusWord, maskWord;

      assign linkSel[g] = vio_q && (address_q[7:4] == 4'(g + 1));

      // Full/empty are taken from the counts at cycle start, so a pop on a
      // full FIFO does not open a slot for a push in the same cycle.
      assign rxFull  = (rxCnt_q == CW'(DEPTH));
      assign rxEmpty = (rxCnt_q == '0);
      assign txFull  = (txCnt_q == CW'(DEPTH));
      assign txEmpty = (txCnt_q == '0);

      assign rxPush = rx_valid[g] & ~rxFull;
      assign rxPop  = hostRd & linkSel[g] & (offset == OFF_DATA) & ~rxEmpty;
      assign txPush = hostWr & linkSel[g] & (offset == OFF_DATA) & ~txFull;
      assign txPop  = tx_ready[g] & ~txEmpty;
      assign ovfSet = hostWr & linkSel[g] & (offset == OFF_DATA) & txFull;
      assign ovfClr = hostWr & linkSel[g] & (offset == OFF_STAT) & host_din_q[2];

      // Occupancy and sticky overflow next-state.
      always_comb begin
         rxCnt_d = rxCnt_q + CW'(rxPush) - CW'(rxPop);
         txCnt_d = txCnt_q + CW'(txPush) - CW'(txPop);
         ovf_d   = ovf_q;
         if (ovfClr) ovf_d = 1'b0;
         if (ovfSet) ovf_d = 1'b1;
      end

      // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
      always_ff @(posedge clk or negedge resetb) begin
         if (!resetb) begin
            rxWr_q  <= '0;
            rxRd_q  <= '0;
            txWr_q  <= '0;
            txRd_q  <= '0;
            rxCnt_q <= '0;
            txCnt_q <= '0;
            ovf_q   <= 1'b0;
         end else begin
            if (rxPush) rxWr_q <= rxWr_q + PW'(1);
            if (rxPop)  rxRd_q <= rxRd_q + PW'(1);
            if (txPush) txWr_q <= txWr_q + PW'(1);
            if (txPop)  txRd_q <= txRd_q + PW'(1);
            rxCnt_q <= rxCnt_d;
            txCnt_q <= txCnt_d;
            ovf_q   <= ovf_d;
         end
      end

      // Storage needs no reset: emptiness is defined by the counts alone.
      always_ff @(posedge clk) begin
         if (rxPush) rxMem_q[rxWr_q] <= rx_data[g*DW +: DW];
         if (txPush) txMem_q[txWr_q] <= host_din_q;
      end

`ifdef LINK_IRQ_EN
      logic mask_q;

      // Per-link interrupt enable, written through offset 2.
      always_ff @(posedge clk or negedge resetb) begin
         if (!resetb) begin
            mask_q <= 1'b0;
         end else if (hostWr && linkSel[g] && (offset == OFF_MASK)) begin
            mask_q <= host_din_q[0];
         end
      end

      assign maskWord  = DW'(mask_q);
      assign irqReq[g] = mask_q & ~rxEmpty;
`else
      assign maskWord  = '0;
`endif

      assign rxHead     = rxEmpty ? '0 : rxMem_q[rxRd_q];
      assign statusWord = DW'({rxCnt_q, ovf_q, ~rxEmpty, ~txFull});

      assign rdData[g] = !(hostRd && linkSel[g]) ? '0 :
                         (offset == OFF_DATA)    ? rxHead :
                         (offset == OFF_STAT)    ? statusWord :
                         (offset == OFF_MASK)    ? maskWord : '0;

      assign rx_ready[g]          = ~rxFull;
      assign tx_valid[g]          = ~txEmpty;
      assign tx_data[g*DW +: DW]  = txEmpty ? '0 : txMem_q[txRd_q];
   end

   // At most one link is selected, so OR-ing the per-link read data is a mux.
   always_comb begin
      host_dout = '0;
      for (int i = 0; i < NLINKS; i++) begin
         host_dout = host_dout | rdData[i];
      end
   end

`ifdef LINK_IRQ_EN
   // Interrupt is registered, so it follows a rising dor by one cycle.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |irqReq;
      end
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_link_io_hub.sv
// tb_link_io_hub
//   Self-checking bench for link_io_hub with default parameters. A queue-based
//   model of every FIFO predicts stream handshakes and host read data each
//   cycle; directed scenarios are followed by randomized traffic.
//   Define LINK_IRQ_EN for both bench and design to exercise the irq feature.
module tb_link_io_hub;

   localparam int NL    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 20;

   logic            clk = 1'b0;
   logic            resetb;
   logic            vio;
   logic            rnw;
   logic [AW-1:0]   address;
   logic [DW-1:0]   host_din;
   logic [DW-1:0]   host_dout;
   logic [NL*DW-1:0] rx_data;
   logic [NL-1:0]   rx_valid;
   logic [NL-1:0]   rx_ready;
   logic [NL*DW-1:0] tx_data;
   logic [NL-1:0]   tx_valid;
   logic [NL-1:0]   tx_ready;
`ifdef LINK_IRQ_EN
   logic            irq;
`endif

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: FIFO contents as queues, sticky flags, pending host op.
   logic [DW-1:0] rxQ [NL][$];
   logic [DW-1:0] txQ [NL][$];
   bit            ovfM  [NL];
   bit            maskM [NL];
   bit            pVio;
   bit            pRnw;
   logic [AW-1:0] pAddr;
   logic [DW-1:0] pDin;
   bit            irqExp;

   link_io_hub #(.NLINKS(NL), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .resetb    (resetb),
      .vio       (vio),
      .rnw       (rnw),
      .address   (address),
      .host_din  (host_din),
      .host_dout (host_dout),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
`ifdef LINK_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [DW-1:0] statusOf(input int i);
      int s;
      s = 0;
      if (txQ[i].size() < DEPTH) s += 1;
      if (rxQ[i].size() > 0)     s += 2;
      if (ovfM[i])               s += 4;
      s += rxQ[i].size() * 8;
      return DW'(s);
   endfunction

   function automatic logic [DW-1:0] expHostDout();
      int lnk;
      int i;
      if (!(pVio && pRnw)) return '0;
      lnk = int'(pAddr[7:4]);
      if (lnk < 1 || lnk > NL) return '0;
      i = lnk - 1;
      case (int'(pAddr[3:0]))
         0: return (rxQ[i].size() == 0) ? '0 : rxQ[i][0];
         1: return statusOf(i);
         2: begin
`ifdef LINK_IRQ_EN
            return DW'(maskM[i]);
`else
            return '0;
`endif
         end
         default: return '0;
      endcase
   endfunction

   // Advance the model across one rising edge using the inputs currently
   // driven, then compare every output just after the edge.
   task automatic tick();
      int rxSz [NL];
      int txSz [NL];
      int off;
      bit sel;
      bit irqNext;
      irqNext = 1'b0;
      off = int'(pAddr[3:0]);
      for (int i = 0; i < NL; i++) begin
         rxSz[i] = rxQ[i].size();
         txSz[i] = txQ[i].size();
      end
      for (int i = 0; i < NL; i++) begin
         sel = pVio && (int'(pAddr[7:4]) == i + 1);
         if (maskM[i] && rxSz[i] > 0) irqNext = 1'b1;
         if (sel && pRnw && off == 0 && rxSz[i] > 0) void'(rxQ[i].pop_front());
         if (rx_valid[i] && rxSz[i] < DEPTH) rxQ[i].push_back(rx_data[i*DW +: DW]);
         if (tx_ready[i] && txSz[i] > 0) void'(txQ[i].pop_front());
         if (sel && !pRnw && off == 0) begin
            if (txSz[i] < DEPTH) txQ[i].push_back(pDin);
            else ovfM[i] = 1'b1;
         end
         if (sel && !pRnw && off == 1 && pDin[2]) ovfM[i] = 1'b0;
`ifdef LINK_IRQ_EN
         if (sel && !pRnw && off == 2) maskM[i] = pDin[0];
`endif
      end
      pVio  = vio;
      pRnw  = rnw;
      pAddr = address;
      pDin  = host_din;
      @(posedge clk);
      #1;
      irqExp = irqNext;
      for (int i = 0; i < NL; i++) begin
         checkOutput($sformatf("rx_ready[%0d]", i), 64'(rx_ready[i]), 64'(rxQ[i].size() < DEPTH));
         checkOutput($sformatf("tx_valid[%0d]", i), 64'(tx_valid[i]), 64'(txQ[i].size() > 0));
         if (txQ[i].size() > 0)
            checkOutput($sformatf("tx_data[%0d]", i), 64'(tx_data[i*DW +: DW]), 64'(txQ[i][0]));
      end
      checkOutput("host_dout", 64'(host_dout), 64'(expHostDout()));
`ifdef LINK_IRQ_EN
      checkOutput("irq", 64'(irq), 64'(irqExp));
`endif
   endtask

   task automatic hostAccess(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output logic [DW-1:0] rd);
      vio      = 1'b1;
      rnw      = r;
      address  = a;
      host_din = d;
      tick();
      rd  = host_dout;
      vio = 1'b0;
      tick();
   endtask

   task automatic applyReset();
      resetb = 1'b0;
      #1;
      for (int i = 0; i < NL; i++) begin
         rxQ[i].delete();
         txQ[i].delete();
         ovfM[i]  = 1'b0;
         maskM[i] = 1'b0;
      end
      pVio   = 1'b0;
      pRnw   = 1'b0;
      pAddr  = '0;
      pDin   = '0;
      irqExp = 1'b0;
      checkOutput("rst_host_dout", 64'(host_dout), 64'(0));
      checkOutput("rst_tx_valid", 64'(tx_valid), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      vio      = 1'b0;
      rx_valid = '0;
      tx_ready = '0;
      resetb   = 1'b1;
      checkOutput("rst_rx_ready", 64'(rx_ready), 64'({NL{1'b1}}));
   endtask

   task automatic applyStimulus(input int cycles);
      int lnk;
      int off;
      for (int c = 0; c < cycles; c++) begin
         rx_valid = NL'($urandom);
         tx_ready = NL'($urandom);
         for (int i = 0; i < NL; i++) rx_data[i*DW +: DW] = $urandom;
         lnk = $urandom_range(0, NL + 1);
         off = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2);
         vio      = ($urandom_range(0, 2) != 0);
         rnw      = ($urandom_range(0, 2) != 0);
         address  = (AW'($urandom) & ~AW'(8'hff)) | AW'(lnk * 16 + off);
         host_din = $urandom;
         tick();
      end
      vio      = 1'b0;
      rx_valid = '0;
      tx_ready = '0;
   endtask

   initial begin : main
      logic [DW-1:0] rd;
      logic [DW-1:0] words [4];

      vio      = 1'b0;
      rnw      = 1'b0;
      address  = '0;
      host_din = '0;
      rx_data  = '0;
      rx_valid = '0;
      tx_ready = '0;
      applyReset();
      tick();

      // Loopback: host write to link 2 appears on its TX stream.
      hostAccess(1'b0, AW'(12'h030), 32'hDEADBEEF, rd);
      checkOutput("loop_valid", 64'(tx_valid[2]), 64'(1));
      checkOutput("loop_data", 64'(tx_data[2*DW +: DW]), 64'(32'hDEADBEEF));
      tx_ready = 4'b0100;
      tick();
      checkOutput("loop_drained", 64'(tx_valid[2]), 64'(0));
      tx_ready = '0;

      // RX fill on link 0 to DEPTH words, then drain through the host.
      for (int k = 0; k < 4; k++) begin
         words[k] = $urandom;
         rx_valid = 4'b0001;
         rx_data[0 +: DW] = words[k];
         tick();
      end
      rx_valid = '0;
      checkOutput("fill_ready", 64'(rx_ready[0]), 64'(0));
      // Full RX (occupancy 4 << 3), dor set, TX not full: 0x20 | 0x2 | 0x1.
      hostAccess(1'b1, AW'(12'h011), '0, rd);
      checkOutput("fill_status", 64'(rd), 64'(32'h23));
      for (int k = 0; k < 4; k++) begin
         hostAccess(1'b1, AW'(12'h010), '0, rd);
         checkOutput("fill_read", 64'(rd), 64'(words[k]));
      end
      hostAccess(1'b1, AW'(12'h010), '0, rd);
      checkOutput("fill_empty_read", 64'(rd), 64'(0));

      // Overflow on link 1: five writes into a four-deep TX with no sink.
      for (int k = 0; k < 5; k++) hostAccess(1'b0, AW'(12'h020), DW'(k + 1), rd);
      // TX full so dir=0, RX empty so dor=0, ovf=1.
      hostAccess(1'b1, AW'(12'h021), '0, rd);
      checkOutput("ovf_status", 64'(rd), 64'(32'h4));
      hostAccess(1'b0, AW'(12'h021), 32'h4, rd);
      hostAccess(1'b1, AW'(12'h021), '0, rd);
      checkOutput("ovf_cleared", 64'(rd), 64'(32'h0));
      tx_ready = 4'b0010;
      repeat (4) tick();
      tx_ready = '0;
      checkOutput("ovf_drained", 64'(tx_valid[1]), 64'(0));

      // Concurrent push and host pop on link 3 at occupancy 2.
      words[0] = $urandom;
      words[1] = $urandom;
      words[2] = $urandom;
      rx_valid = 4'b1000;
      rx_data[3*DW +: DW] = words[0];
      tick();
      rx_data[3*DW +: DW] = words[1];
      tick();
      rx_valid = '0;
      vio      = 1'b1;
      rnw      = 1'b1;
      address  = AW'(12'h040);
      tick();
      checkOutput("conc_head", 64'(host_dout), 64'(words[0]));
      vio      = 1'b0;
      rx_valid = 4'b1000;
      rx_data[3*DW +: DW] = words[2];
      tick();
      rx_valid = '0;
      // Occupancy 2 (0x10), dor (0x2), dir (0x1).
      hostAccess(1'b1, AW'(12'h041), '0, rd);
      checkOutput("conc_status", 64'(rd), 64'(32'h13));
      hostAccess(1'b1, AW'(12'h040), '0, rd);
      checkOutput("conc_read1", 64'(rd), 64'(words[1]));
      hostAccess(1'b1, AW'(12'h040), '0, rd);
      checkOutput("conc_read2", 64'(rd), 64'(words[2]));

`ifdef LINK_IRQ_EN
      // Masked dor on link 3 raises irq one cycle later; emptying clears it.
      hostAccess(1'b0, AW'(12'h042), 32'h1, rd);
      rx_valid = 4'b1000;
      rx_data[3*DW +: DW] = 32'h0000_0DD5;
      tick();
      rx_valid = '0;
      checkOutput("irq_before", 64'(irq), 64'(0));
      tick();
      checkOutput("irq_raised", 64'(irq), 64'(1));
      hostAccess(1'b1, AW'(12'h040), '0, rd);
      tick();
      checkOutput("irq_cleared", 64'(irq), 64'(0));
`endif

      applyStimulus(300);

      // Reset in the middle of live traffic discards everything.
      for (int i = 0; i < NL; i++) rx_data[i*DW +: DW] = $urandom;
      rx_valid = '1;
      tx_ready = '1;
      hostAccess(1'b0, AW'(12'h010), 32'h1234_5678, rd);
      applyReset();
      tick();
      checkOutput("mid_rst_tx_valid", 64'(tx_valid), 64'(0));
      for (int i = 0; i < NL; i++) begin
         hostAccess(1'b1, AW'((i + 1) * 16 + 1), '0, rd);
         checkOutput($sformatf("mid_rst_status[%0d]", i), 64'(rd), 64'(32'h1));
      end

      applyStimulus(300);
      repeat (DEPTH + 2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
